// File: rtl/divider_pkg.sv
// Shared sizing and state types for the restoring divider and its benches.
package divider_pkg;

  localparam int DIV_MBITS     = 16;
  localparam int DIV_NBITS     = 16;
  localparam int DIV_COUNTBITS = 5;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    RES_OK,
    RES_DBZ,
    RES_OVF
  } res_e;

endpackage

// File: rtl/divider_alu.sv
// divALU: (MBITS+1)-bit subtractor returning difference and borrow for one restoring step.
module divALU
  import divider_pkg::*;
#(
  parameter int MBITS = DIV_MBITS
) (
  input  logic [MBITS:0] a,
  input  logic [MBITS:0] b,
  output logic [MBITS:0] diff,
  output logic           borrow
);

  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/divider.sv
// Restoring divider, one quotient bit per cycle, fixed NBITS+1 cycle latency.
// Define DIVIDER_SIGNED_EN for two's complement operands with sign fix-up.
module divider
  import divider_pkg::*;
#(
  parameter int MBITS     = DIV_MBITS,
  parameter int NBITS     = DIV_NBITS,
  parameter int COUNTBITS = DIV_COUNTBITS
) (
  input  logic                   wClk,
  input  logic                   nRst,
  input  logic                   start,
  input  logic [MBITS+NBITS-1:0] xDvd,
  input  logic [MBITS-1:0]       xDvs,
  output logic [NBITS-1:0]       xQuot,
  output logic [MBITS-1:0]       xRem,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   dbz
);

  localparam int DW = MBITS + NBITS;
  localparam logic [COUNTBITS-1:0] LAST = COUNTBITS'(NBITS);

  state_e               state;
  res_e                 resPend;
  logic [COUNTBITS-1:0] count;
  logic [MBITS-1:0]     rem;
  logic [NBITS-1:0]     dq;
  logic [MBITS-1:0]     dvsMag;
  logic [DW-1:0]        dvdMag;
  logic [MBITS-1:0]     dvsInMag;
  logic [MBITS:0]       aluDiff;
  logic                 aluBorrow;
  logic                 keep;

`ifdef DIVIDER_SIGNED_EN
  logic signed [DW-1:0]    dvdS;
  logic signed [MBITS-1:0] dvsS;
  logic                    dvdNeg;
  logic                    quotNeg;

  assign dvdS     = xDvd;
  assign dvsS     = xDvs;
  assign dvdMag   = (dvdS < 0) ? -dvdS : dvdS;
  assign dvsInMag = (dvsS < 0) ? -dvsS : dvsS;

  // Most negative result is allowed one more unit of magnitude than the most positive.
  function automatic logic range_ovf(input logic [NBITS-1:0] mag, input logic neg);
    return neg ? (mag[NBITS-1] & (|mag[NBITS-2:0])) : mag[NBITS-1];
  endfunction

  function automatic logic [NBITS-1:0] fix_quot(input logic [NBITS-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [MBITS-1:0] fix_rem(input logic [MBITS-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction
`else
  assign dvdMag   = xDvd;
  assign dvsInMag = xDvs;
`endif

  divALU #(.MBITS(MBITS)) u_alu (
    .a      ({rem, dq[NBITS-1]}),
    .b      ({1'b0, dvsMag}),
    .diff   (aluDiff),
    .borrow (aluBorrow)
  );

  // Keep the difference only when it is non-negative and fits the remainder width.
  assign keep = ~(aluBorrow | aluDiff[MBITS]);

  always_ff @(posedge wClk) begin
    if (!nRst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
      xQuot <= '0;
      xRem  <= '0;
      count <= '0;
    end else if (start) begin
      state  <= ST_RUN;
      busy   <= 1'b1;
      done   <= 1'b0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
      xQuot  <= '0;
      xRem   <= '0;
      count  <= '0;
      rem    <= dvdMag[DW-1:NBITS];
      dq     <= dvdMag[NBITS-1:0];
      dvsMag <= dvsInMag;
      if (dvsInMag == '0)
        resPend <= RES_DBZ;
      else if (dvdMag[DW-1:NBITS] >= dvsInMag)
        resPend <= RES_OVF;
      else
        resPend <= RES_OK;
`ifdef DIVIDER_SIGNED_EN
      dvdNeg  <= xDvd[DW-1];
      quotNeg <= xDvd[DW-1] ^ xDvs[MBITS-1];
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (count == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            case (resPend)
              RES_DBZ: begin
                dbz   <= 1'b1;
                xQuot <= '1;
                xRem  <= '0;
              end
              RES_OVF: begin
                ovf   <= 1'b1;
                xQuot <= '1;
                xRem  <= '0;
              end
              default: begin
`ifdef DIVIDER_SIGNED_EN
                if (range_ovf(dq, quotNeg)) begin
                  ovf   <= 1'b1;
                  xQuot <= '1;
                  xRem  <= '0;
                end else begin
                  xQuot <= fix_quot(dq, quotNeg);
                  xRem  <= fix_rem(rem, dvdNeg);
                end
`else
                xQuot <= dq;
                xRem  <= rem;
`endif
              end
            endcase
          end else begin
            rem   <= keep ? aluDiff[MBITS-1:0] : {rem[MBITS-2:0], dq[NBITS-1]};
            dq    <= {dq[NBITS-2:0], keep};
            count <= count + COUNTBITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
